mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- HI/LO multiply-divide unit that consumes the EXE stage's operand pair, the 6-bit multiply/divide op and the HI/LO read request.
- Performs MULT/MULTU in a single cycle and DIV/DIVU with an iterative 32-step restoring divider.
- Applies MTHI/MTLO writes and serves MFHI/MFLO reads.
- Back-pressures EXE through mdu_ready_out, which EXE uses as its stage-ready term.

Parameters:
WIDTH, 32, operand/HI/LO width; only 32 is supported.
HILO_RST_VAL, 0, reset value of the HI and LO registers.

Ports:
clk  input  1  clock.
rst_n  input  1  reset; asynchronous, active-low.
exe_in0_in  input  32  operand rs (dividend/multiplicand; MTHI/MTLO source).
exe_in1_in  input  32  operand rt (divisor/multiplier).
exe_mult_div_op_in  input  6  one-hot, already masked with EXE valid: [5] MTHI, [4] MTLO, [3] MULT, [2] MULTU, [1] DIV, [0] DIVU; all-zero = none.
exe_read_request_in  input  1  EXE instruction is MFHI/MFLO.
exe_read_hi_in  input  1  1 = read HI, 0 = read LO.
exe_go_in  input  1  EXE instruction leaves EXE this cycle (EXE valid && ready && MEM allowin).
exc_flush_in  input  1  pipeline flush; aborts any op in flight.
mdu_ready_out  output  1  0 = EXE must hold its instruction.
mdu_rdata_out  output  32  HI or LO per exe_read_hi_in, combinational from the registers.
mdu_hi_out  output  32  current HI.
mdu_lo_out  output  32  current LO.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE; HI = LO = HILO_RST_VAL; count = 0.
  - mdu_ready_out = 1; mdu_rdata_out = HILO_RST_VAL.
- States:
  - IDLE.
  - DIV_RUN: 32 iterations, 6-bit count.
  - DIV_FIX: sign correction and HI/LO write.
  - DONE: result held until EXE leaves.
- mdu_ready_out = 0 when (IDLE and op[1]|op[0]) or DIV_RUN or DIV_FIX; otherwise 1.
- IDLE with op[5|4|3|2] and exe_go_in=1: update at that clock edge.
  - MTHI: HI <= in0. MTLO: LO <= in0.
  - MULT: {HI,LO} <= signed 64-bit product.
  - MULTU: {HI,LO} <= unsigned 64-bit product.
  - No write when exe_go_in=0; the op stays pending and is re-presented by EXE.
- IDLE with DIV/DIVU (cycle 0):
  - Latch |in0| and |in1| (raw values for DIVU).
  - Latch quotient sign = in0[31]^in1[31] and remainder sign = in0[31] (signed only).
  - Clear the partial remainder; go to DIV_RUN.
- DIV_RUN (cycles 1..32):
  - One restoring step per cycle: shift {rem,quo} left by 1, trial-subtract divisor, set quotient bit if the result is non-negative.
  - After step 32, go to DIV_FIX.
- DIV_FIX (cycle 33):
  - Negate the quotient/remainder where the sign flags require.
  - LO <= quotient, HI <= remainder; go to DONE.
- DONE (cycle 34 onward):
  - mdu_ready_out = 1.
  - exe_go_in=1 -> IDLE; otherwise stay, with no restart and no rewrite.
- Divisor = 0: run full latency, HI/LO unchanged.
- Signed corner case: 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0. The absolute value is handled as unsigned 32-bit.
- exc_flush_in=1, any state:
  - Next state IDLE; HI/LO unchanged; no pending write.
  - Flush takes priority over exe_go_in in the same cycle.
- Reset mid-division: immediate abort; HI/LO return to HILO_RST_VAL.
- Reads: mdu_rdata_out always reflects the registered HI/LO, so no forwarding is needed.
  - A MULT that leaves EXE in cycle N is visible to an MFHI in EXE in cycle N+1.
- exe_read_request_in never coincides with a busy state; while busy it is ignored.

Optional Feature:
- Macro: MDU_DIV_BYPASS_EN.
- Defined: in IDLE, a DIV/DIVU with |divisor| > |dividend| (magnitudes after abs), and divisor ≠ 0, skips DIV_RUN/DIV_FIX.
  - LO <= 0, HI <= original signed dividend; go directly to DONE next cycle.
  - mdu_ready_out = 0 for one cycle only.
- Undefined: every division takes the full 34-cycle path.

Test Plan:
- MULT in0=0xFFFFFFFF, in1=0x00000002, exe_go_in=1 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFE, mdu_ready_out stays 1.
- MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE; then MFHI (read_request=1, read_hi=1) -> mdu_rdata_out=0x00000001.
- DIV in0=0xFFFFFFF9 (-7), in1=2, exe_go_in held 1:
  - mdu_ready_out low cycles 0..33, high cycle 34.
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/7 with exe_go_in=0 during DONE for 3 cycles:
  - State holds DONE, LO=14, HI=2, no restart.
  - exe_go_in=1 -> IDLE.
- DIV started, exc_flush_in=1 at cycle 10 -> IDLE at cycle 11, HI/LO unchanged, mdu_ready_out=1.
- DIVU 5/9:
  - With MDU_DIV_BYPASS_EN: ready low one cycle, LO=0, HI=5.
  - Without the macro: 34-cycle latency, same result.

Source files
------------

// File: rtl/mul_div_unit.sv
// HI/LO multiply-divide unit: single-cycle MULT/MULTU, 32-step restoring DIV/DIVU, MTHI/MTLO, MFHI/MFLO.
// Optional macro MDU_DIV_BYPASS_EN: early-out for divisions whose divisor magnitude exceeds the dividend's.
module mul_div_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] HILO_RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] exe_in0_in,
  input  logic [WIDTH-1:0] exe_in1_in,
  input  logic [5:0]       exe_mult_div_op_in,
  input  logic             exe_read_request_in,
  input  logic             exe_read_hi_in,
  input  logic             exe_go_in,
  input  logic             exc_flush_in,
  output logic             mdu_ready_out,
  output logic [WIDTH-1:0] mdu_rdata_out,
  output logic [WIDTH-1:0] mdu_hi_out,
  output logic [WIDTH-1:0] mdu_lo_out
);

  typedef enum logic [1:0] {S_IDLE, S_DIV_RUN, S_DIV_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [5:0]       count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d, quo_q, quo_d, rem_q, rem_d;
  logic             qsign_q, qsign_d, rsign_q, rsign_d;

  function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = v[WIDTH-1] ? -v : v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  logic op_mthi, op_mtlo, op_mult, op_multu, op_div, op_divu, op_div_any;
  assign op_mthi    = exe_mult_div_op_in[5];
  assign op_mtlo    = exe_mult_div_op_in[4];
  assign op_mult    = exe_mult_div_op_in[3];
  assign op_multu   = exe_mult_div_op_in[2];
  assign op_div     = exe_mult_div_op_in[1];
  assign op_divu    = exe_mult_div_op_in[0];
  assign op_div_any = op_div | op_divu;

  logic signed [2*WIDTH-1:0] a_s, b_s, prod_s;
  logic        [2*WIDTH-1:0] a_u, b_u, prod_u;
  assign a_s    = {{WIDTH{exe_in0_in[WIDTH-1]}}, exe_in0_in};
  assign b_s    = {{WIDTH{exe_in1_in[WIDTH-1]}}, exe_in1_in};
  assign prod_s = a_s * b_s;
  assign a_u    = {{WIDTH{1'b0}}, exe_in0_in};
  assign b_u    = {{WIDTH{1'b0}}, exe_in1_in};
  assign prod_u = a_u * b_u;

  logic [WIDTH-1:0] abs_a, abs_b;
  assign abs_a = op_div ? abs_mag(exe_in0_in) : exe_in0_in;
  assign abs_b = op_div ? abs_mag(exe_in1_in) : exe_in1_in;

  logic bypass;
`ifdef MDU_DIV_BYPASS_EN
  // Quotient is zero and remainder is the dividend; a zero divisor never satisfies the compare.
  assign bypass = op_div_any && (abs_b > abs_a);
`else
  assign bypass = 1'b0;
`endif

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  logic [WIDTH:0] rem_sh, trial;
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvsr_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      hi_q    <= HILO_RST_VAL;
      lo_q    <= HILO_RST_VAL;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    dvsr_q  <= dvsr_d;
    quo_q   <= quo_d;
    rem_q   <= rem_d;
    qsign_q <= qsign_d;
    rsign_q <= rsign_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (op_div_any) state_d = bypass ? S_DONE : S_DIV_RUN;
      S_DIV_RUN: if (count_q == 6'd31) state_d = S_DIV_FIX;
      S_DIV_FIX: state_d = S_DONE;
      S_DONE:    if (exe_go_in) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (exc_flush_in) state_d = S_IDLE;
  end

  always_comb begin
    mdu_ready_out = 1'b1;
    unique case (state_q)
      S_IDLE:                mdu_ready_out = ~op_div_any;
      S_DIV_RUN, S_DIV_FIX:  mdu_ready_out = 1'b0;
      default:               mdu_ready_out = 1'b1;
    endcase
  end

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
    dvsr_d  = dvsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    if (!exc_flush_in) begin
      unique case (state_q)
        S_IDLE: begin
          if (exe_go_in) begin
            if (op_mthi)  hi_d = exe_in0_in;
            if (op_mtlo)  lo_d = exe_in0_in;
            if (op_mult)  {hi_d, lo_d} = prod_s;
            if (op_multu) {hi_d, lo_d} = prod_u;
          end
          if (op_div_any) begin
            dvsr_d  = abs_b;
            quo_d   = abs_a;
            rem_d   = '0;
            qsign_d = op_div & (exe_in0_in[WIDTH-1] ^ exe_in1_in[WIDTH-1]);
            rsign_d = op_div & exe_in0_in[WIDTH-1];
            count_d = '0;
            if (bypass) begin
              lo_d = '0;
              hi_d = exe_in0_in;
            end
          end
        end
        S_DIV_RUN: begin
          count_d = count_q + 6'd1;
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end
        S_DIV_FIX: begin
          // Division by zero leaves HI/LO untouched.
          if (dvsr_q != '0) begin
            lo_d = cond_neg(quo_q, qsign_q);
            hi_d = cond_neg(rem_q, rsign_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign mdu_rdata_out = exe_read_hi_in ? hi_q : lo_q;
  assign mdu_hi_out    = hi_q;
  assign mdu_lo_out    = lo_q;

  // EXE only issues MFHI/MFLO once the unit is no longer busy.
  assert property (@(posedge clk) disable iff (!rst_n)
    !(exe_read_request_in && (state_q == S_DIV_RUN || state_q == S_DIV_FIX)));

endmodule
